picorv32_pcpi_initiator: RTL and testbench
==========================================

Name: picorv32_pcpi_initiator

Overview:
Core-side master for the PCPI coprocessor interface. It accepts one instruction plus two operands on a valid/ready request port and drives pcpi_valid/insn/rs1/rs2 until a coprocessor asserts pcpi_ready. It returns the write flag and result on a valid/ready response port. If no coprocessor responds and none signals pcpi_wait within the timeout window, it returns an error response, which the core traps as an illegal instruction.

Parameters:
TIMEOUT_CYCLES, 16, reload value of the timeout counter (1..255); 0 disables timeout.
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
resetn  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_insn  in  32  instruction word
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_wr  out  1  coprocessor requested register write
rsp_rd  out  32  result value
rsp_err  out  1  timeout; no coprocessor claimed the instruction
pcpi_valid  out  1  PCPI request valid
pcpi_insn  out  32  PCPI instruction
pcpi_rs1  out  32  PCPI operand 1
pcpi_rs2  out  32  PCPI operand 2
pcpi_wr  in  1  coprocessor write flag
pcpi_rd  in  32  coprocessor result
pcpi_wait  in  1  coprocessor claims the instruction; still busy
pcpi_ready  in  1  coprocessor done
busy  out  1  state != IDLE

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset, state=IDLE, pcpi_valid=0, pcpi_insn/rs1/rs2=0, rsp_valid=0, rsp_wr=0, rsp_rd=0, rsp_err=0, counter=0. Reset mid-transaction aborts it: pcpi_valid=0 after that edge and no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1 (combinational from state; 0 in every other state).
  - On handshake: register insn/rs1/rs2 onto the pcpi_* outputs, set pcpi_valid=1, counter<=TIMEOUT_CYCLES, go to ISSUE.
- ISSUE:
  - pcpi_valid=1; pcpi_insn/rs1/rs2 stable throughout.
  - If pcpi_ready=1: rsp_wr<=pcpi_wr; rsp_rd<=pcpi_wr ? pcpi_rd : 0; rsp_err<=0; pcpi_valid<=0; rsp_valid<=1; go to RESP. pcpi_valid therefore drops on the edge after ready is sampled, and ready is sampled only once.
  - Else if pcpi_wait=1: counter<=TIMEOUT_CYCLES (reload).
  - Else if TIMEOUT_CYCLES!=0 and counter==0: rsp_err<=1, rsp_wr<=0, rsp_rd<=0, pcpi_valid<=0, rsp_valid<=1; go to RESP.
  - Else: counter<=counter-1 when TIMEOUT_CYCLES!=0; with timeout disabled, wait indefinitely.
- Timeout latency: a request with pcpi_ready and pcpi_wait never asserted holds pcpi_valid for exactly TIMEOUT_CYCLES+1 cycles.
- Priority: pcpi_ready beats pcpi_wait, and both beat timeout in the same cycle.
- RESP:
  - rsp_valid=1 and rsp_wr/rd/err held stable until rsp_ready.
  - On handshake: rsp_valid<=0, go to IDLE.
  - The next request can be accepted one cycle after the response handshake, so back-to-back issue takes a minimum of 3 cycles per transaction.
- pcpi_ready/pcpi_wait/pcpi_wr/pcpi_rd are ignored in IDLE and RESP; spurious ready produces no response.
- Responder-latency compatibility: a responder that asserts ready 1 to N cycles after seeing pcpi_valid, with no wait, completes correctly provided N ≤ TIMEOUT_CYCLES.
- Outputs are registered except req_ready and busy.

Test Plan:
1. Model responder with ready 2 cycles after valid, wr=1, rd=rs1*rs2. Request insn=0x02A38533 (mul), rs1=7, rs2=6 → pcpi_valid high 2 cycles; rsp_valid, rsp_wr=1, rsp_rd=42, rsp_err=0.
2. No responder, TIMEOUT_CYCLES=16 → pcpi_valid high exactly 17 cycles; then rsp_err=1, rsp_wr=0, rsp_rd=0.
3. Responder holds wait=1 for 40 cycles, then ready with rd=0xDEADBEEF → no timeout; rsp_rd=0xDEADBEEF, rsp_err=0.
4. ready=1 with wr=0 on the same cycle counter hits 0 → normal response, rsp_wr=0, rsp_rd=0, rsp_err=0 (ready wins).
5. rsp_ready held 0 for 5 cycles; req_valid held high with a new request → req_ready=0 and rsp_* stable throughout; the second request is accepted the cycle after the rsp handshake.
6. resetn=0 during ISSUE cycle 3 → pcpi_valid=0 and rsp_valid=0 after the edge; the late pcpi_ready is ignored; a new request completes normally.

Source files
------------

// File: rtl/picorv32_pcpi_initiator_if.sv
// Request, response and PCPI bus bundle for the PCPI initiator.
// master: initiator side; slave: core plus coprocessor side.
interface picorv32_pcpi_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2,
    output req_ready,
    output rsp_valid, rsp_wr, rsp_rd, rsp_err,
    input  rsp_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2,
    input  req_ready,
    input  rsp_valid, rsp_wr, rsp_rd, rsp_err,
    output rsp_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/picorv32_pcpi_initiator.sv
// PCPI initiator: issues one instruction to the coprocessor bus, returns
// result or timeout error. Ports: clk, resetn (sync, low), bus, busy.
module picorv32_pcpi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic resetn,
  picorv32_pcpi_initiator_if.master bus,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } op_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        err;
  } res_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  res_t             res_q, res_d;
  logic             pv_q, pv_d;
  logic             rv_q, rv_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      pv_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      pv_q    <= pv_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    pv_d    = pv_q;
    rv_d    = rv_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d.insn = bus.req_insn;
          op_d.rs1  = bus.req_rs1;
          op_d.rs2  = bus.req_rs2;
          pv_d      = 1'b1;
          cnt_d     = RELOAD;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // ready beats wait, and both beat the timeout
        if (bus.pcpi_ready) begin
          res_d.wr  = bus.pcpi_wr;
          res_d.rd  = bus.pcpi_wr ? bus.pcpi_rd : '0;
          res_d.err = 1'b0;
          pv_d      = 1'b0;
          rv_d      = 1'b1;
          state_d   = RESP;
        end else if (bus.pcpi_wait) begin
          cnt_d = RELOAD;
        end else if (TO_EN && cnt_q == '0) begin
          res_d.wr  = 1'b0;
          res_d.rd  = '0;
          res_d.err = 1'b1;
          pv_d      = 1'b0;
          rv_d      = 1'b1;
          state_d   = RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    busy           = (state_q != IDLE);
    bus.pcpi_valid = pv_q;
    bus.pcpi_insn  = op_q.insn;
    bus.pcpi_rs1   = op_q.rs1;
    bus.pcpi_rs2   = op_q.rs2;
    bus.rsp_valid  = rv_q;
    bus.rsp_wr     = res_q.wr;
    bus.rsp_rd     = res_q.rd;
    bus.rsp_err    = res_q.err;
  end

endmodule

// File: tb/tb_picorv32_pcpi_initiator.sv
// Bench for picorv32_pcpi_initiator: scripted responder, timeline model,
// per-cycle compare against expected outputs.
module tb_picorv32_pcpi_initiator;
  localparam int T = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;

  picorv32_pcpi_initiator_if bus ();

  picorv32_pcpi_initiator #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        ck_en = 1'b0;
  logic        e_req_ready, e_busy, e_pv, e_rv, e_rst;
  logic        e_wr, e_err;
  logic [31:0] e_insn, e_rs1, e_rs2, e_rd;

  int          pv_cnt = 0;
  int          n_rsp = 0;
  logic        lr_wr, lr_err;
  logic [31:0] lr_rd;

  logic [31:0] nx_insn, nx_rs1, nx_rs2;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  always @(negedge clk) begin
    if (ck_en) begin
      chk1("req_ready", bus.req_ready, e_req_ready);
      chk1("busy", busy, e_busy);
      chk1("pcpi_valid", bus.pcpi_valid, e_pv);
      chk1("rsp_valid", bus.rsp_valid, e_rv);
      if (e_pv) begin
        chk("pcpi_insn", bus.pcpi_insn, e_insn);
        chk("pcpi_rs1", bus.pcpi_rs1, e_rs1);
        chk("pcpi_rs2", bus.pcpi_rs2, e_rs2);
      end
      if (e_rst) begin
        chk("rst_insn", bus.pcpi_insn, 32'h0);
        chk("rst_rs1", bus.pcpi_rs1, 32'h0);
        chk("rst_rs2", bus.pcpi_rs2, 32'h0);
        chk1("rst_wr", bus.rsp_wr, 1'b0);
        chk("rst_rd", bus.rsp_rd, 32'h0);
        chk1("rst_err", bus.rsp_err, 1'b0);
      end
      if (e_rv) begin
        chk1("rsp_wr", bus.rsp_wr, e_wr);
        chk("rsp_rd", bus.rsp_rd, e_rd);
        chk1("rsp_err", bus.rsp_err, e_err);
      end
      if (bus.pcpi_valid) pv_cnt++;
    end
  end

  always @(posedge clk) begin
    if (resetn && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      lr_wr  = bus.rsp_wr;
      lr_rd  = bus.rsp_rd;
      lr_err = bus.rsp_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.pcpi_ready = 1'($urandom % 2);
    bus.pcpi_wait  = 1'($urandom % 2);
    bus.pcpi_wr    = 1'($urandom % 2);
    bus.pcpi_rd    = $urandom;
  endtask

  task automatic new_req();
    nx_insn = $urandom;
    nx_rs1  = $urandom;
    nx_rs2  = $urandom;
  endtask

  // W: cycles of wait from first issue cycle; R: issue cycle carrying
  // ready (-1 = never); D: rsp_ready stall; hold: present next request
  // during the response; rst_k: issue cycle at which reset hits (-1 none).
  task automatic run_txn(int W, int R, logic wr, logic [31:0] rd,
                         int D, bit hold, int rst_k);
    bit normal;
    int V;
    // wait reloads the count, so silence after the last wait times out
    // T cycles later; ready on or before that cycle wins
    normal = (R >= 0) && (R <= W + T);
    V = normal ? R + 1 : W + T + 1;

    bus.req_valid = 1'b1;
    bus.req_insn  = nx_insn;
    bus.req_rs1   = nx_rs1;
    bus.req_rs2   = nx_rs2;
    tick();
    bus.req_valid = 1'b0;
    bus.req_insn  = $urandom;
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    e_rst = 1'b0;
    e_req_ready = 1'b0;
    e_busy = 1'b1;
    e_pv = 1'b1;
    e_rv = 1'b0;
    e_insn = nx_insn;
    e_rs1 = nx_rs1;
    e_rs2 = nx_rs2;
    pv_cnt = 0;

    for (int k = 0; k < V; k++) begin
      bus.pcpi_wait  = (k < W);
      bus.pcpi_ready = (k == R);
      bus.pcpi_wr    = (k == R) ? wr : 1'($urandom % 2);
      bus.pcpi_rd    = (k == R) ? rd : $urandom;
      bus.rsp_ready  = 1'($urandom % 2);
      if (k == rst_k) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        e_rst = 1'b1;
        e_pv = 1'b0;
        e_rv = 1'b0;
        e_busy = 1'b0;
        e_req_ready = 1'b1;
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_wr    = 1'b1;
        tick();
        tick();
        bus.pcpi_ready = 1'b0;
        new_req();
        return;
      end
      tick();
    end

    e_pv = 1'b0;
    e_rv = 1'b1;
    e_wr = normal && wr;
    e_rd = (normal && wr) ? rd : 32'h0;
    e_err = !normal;
    noise();
    new_req();
    if (hold) begin
      bus.req_valid = 1'b1;
      bus.req_insn  = nx_insn;
      bus.req_rs1   = nx_rs1;
      bus.req_rs2   = nx_rs2;
    end
    bus.rsp_ready = 1'b0;
    for (int d = 0; d < D; d++) begin
      tick();
      noise();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    e_rv = 1'b0;
    e_busy = 1'b0;
    e_req_ready = 1'b1;
    if (!hold) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        noise();
        bus.rsp_ready = 1'($urandom % 2);
        tick();
      end
    end
  endtask

  initial begin
    int rsp0;
    bus.req_valid = 1'b0;
    bus.req_insn  = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.rsp_ready = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    e_req_ready = 1'b1;
    e_busy = 1'b0;
    e_pv = 1'b0;
    e_rv = 1'b0;
    e_rst = 1'b1;
    e_wr = 1'b0;
    e_err = 1'b0;
    e_rd = '0;
    e_insn = '0;
    e_rs1 = '0;
    e_rs2 = '0;
    resetn = 1'b0;
    tick();
    ck_en = 1'b1;
    tick();
    resetn = 1'b1;
    tick();

    // 1: mul, ready on second issue cycle
    nx_insn = 32'h02A38533;
    nx_rs1 = 32'd7;
    nx_rs2 = 32'd6;
    run_txn(0, 1, 1'b1, 32'd7 * 32'd6, 0, 1'b0, -1);
    chk("t1_pv_cycles", pv_cnt, 32'd2);
    chk1("t1_wr", lr_wr, 1'b1);
    chk("t1_rd", lr_rd, 32'd42);
    chk1("t1_err", lr_err, 1'b0);

    // 2: nobody answers
    run_txn(0, -1, 1'b1, 32'h1234, 1, 1'b0, -1);
    chk("t2_pv_cycles", pv_cnt, 32'd17);
    chk1("t2_wr", lr_wr, 1'b0);
    chk("t2_rd", lr_rd, 32'd0);
    chk1("t2_err", lr_err, 1'b1);

    // 3: long wait then ready
    run_txn(40, 40, 1'b1, 32'hDEADBEEF, 0, 1'b0, -1);
    chk("t3_pv_cycles", pv_cnt, 32'd41);
    chk("t3_rd", lr_rd, 32'hDEADBEEF);
    chk1("t3_err", lr_err, 1'b0);

    // 4: ready with wr=0 on the timeout cycle
    run_txn(0, T, 1'b0, 32'hA5A5A5A5, 0, 1'b0, -1);
    chk("t4_pv_cycles", pv_cnt, 32'd17);
    chk1("t4_wr", lr_wr, 1'b0);
    chk("t4_rd", lr_rd, 32'd0);
    chk1("t4_err", lr_err, 1'b0);

    // 5: response stalled 5 cycles with next request pending
    run_txn(2, 3, 1'b1, 32'h0BADF00D, 5, 1'b1, -1);
    chk("t5_rd", lr_rd, 32'h0BADF00D);
    run_txn(0, 0, 1'b1, 32'h00C0FFEE, 0, 1'b0, -1);
    chk("t5b_rd", lr_rd, 32'h00C0FFEE);

    // 6: reset in the third issue cycle, late ready ignored
    rsp0 = n_rsp;
    run_txn(0, 5, 1'b1, 32'h11111111, 0, 1'b0, 2);
    chk("t6_pv_cycles", pv_cnt, 32'd3);
    chk("t6_no_rsp", n_rsp, rsp0);
    run_txn(1, 2, 1'b1, 32'h22222222, 0, 1'b0, -1);
    chk("t6_after_rd", lr_rd, 32'h22222222);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int w, r, d;
      bit h;
      w = ($urandom % 2 == 0) ? 0 : $urandom_range(1, 20);
      r = ($urandom % 4 == 0) ? -1 : $urandom_range(0, w + T + 3);
      d = $urandom_range(0, 3);
      h = 1'($urandom % 2);
      run_txn(w, r, 1'($urandom % 2), $urandom, d, h, -1);
    end
    bus.req_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
